// File: rtl/conv_ctrl_param.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | conv_ctrl_param: sequencer for a parameterised convolution filter bank.    |
// |   Filter load, row fill, per-window MAC, write-back and row shift.         |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module conv_ctrl_param #(
    parameter int FILT_ROWS = 4,
    parameter int NUM_FILT  = 2,
    parameter int ROW_W     = (FILT_ROWS > 1) ? $clog2(FILT_ROWS) : 1,
    parameter int FILT_W    = (NUM_FILT > 1) ? $clog2(NUM_FILT) : 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              mem_ready,
    input  logic              filt_cout,
    input  logic              input_j_cout,
    input  logic              calc_done,
    input  logic              write_mem_cout,
    input  logic              table_cout,
    input  logic              it_ends,
    output logic              busy,
    output logic              done,
    output logic              base_ld,
    output logic              in_rewind,
    output logic              out_base_en,
    output logic              mem_rd,
    output logic              mem_wr,
    output logic [1:0]        mem_in_sel,
    output logic              filt_ld,
    output logic              filt_count_en,
    output logic              input_en,
    output logic              input_count_en,
    output logic [ROW_W-1:0]  input_row,
    output logic              tab_count_ld,
    output logic              table_ld,
    output logic              mac_rst,
    output logic              mac_ld,
    output logic              calc_count_en,
    output logic              write_buf_ld,
    output logic              wr_count_en,
    output logic              win_count_en,
    output logic              shift_en,
    output logic              in_count_en,
    output logic [FILT_W-1:0] filt_idx
);

    typedef enum logic [3:0] {
        S_IDLE      = 4'd0,
        S_INIT      = 4'd1,
        S_LD_FILT   = 4'd2,
        S_LD_ROW    = 4'd3,
        S_SETUP     = 4'd4,
        S_WIN       = 4'd5,
        S_CALC      = 4'd6,
        S_BUF       = 4'd7,
        S_ADV       = 4'd8,
        S_WRITE     = 4'd9,
        S_SHIFT     = 4'd10,
        S_NEXT_FILT = 4'd11,
        S_DONE      = 4'd12
    } state_t;

    localparam logic [ROW_W-1:0]  C_LAST_ROW  = ROW_W'(FILT_ROWS - 1);
    localparam logic [FILT_W-1:0] C_LAST_FILT = FILT_W'(NUM_FILT - 1);

    state_t            state_q, state_d;
    logic [ROW_W-1:0]  row_cnt_q, row_cnt_d;
    logic [FILT_W-1:0] filt_idx_q, filt_idx_d;

    always_comb begin
        state_d        = state_q;
        row_cnt_d      = row_cnt_q;
        filt_idx_d     = filt_idx_q;
        busy           = (state_q != S_IDLE);
        done           = 1'b0;
        base_ld        = 1'b0;
        in_rewind      = 1'b0;
        out_base_en    = 1'b0;
        mem_rd         = 1'b0;
        mem_wr         = 1'b0;
        mem_in_sel     = 2'b00;
        filt_ld        = 1'b0;
        filt_count_en  = 1'b0;
        input_en       = 1'b0;
        input_count_en = 1'b0;
        input_row      = '0;
        tab_count_ld   = 1'b0;
        table_ld       = 1'b0;
        mac_rst        = 1'b0;
        mac_ld         = 1'b0;
        calc_count_en  = 1'b0;
        write_buf_ld   = 1'b0;
        wr_count_en    = 1'b0;
        win_count_en   = 1'b0;
        shift_en       = 1'b0;
        in_count_en    = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start) state_d = S_INIT;
            end
            S_INIT: begin
                base_ld    = 1'b1;
                row_cnt_d  = '0;
                filt_idx_d = '0;
                state_d    = S_LD_FILT;
            end
            // Memory states: request stays up while stalled, enables follow acceptance.
            S_LD_FILT: begin
                mem_rd        = 1'b1;
                mem_in_sel    = 2'b01;
                filt_ld       = mem_ready;
                filt_count_en = mem_ready;
                if (filt_cout && mem_ready) begin
                    row_cnt_d = '0;
                    state_d   = S_LD_ROW;
                end
            end
            S_LD_ROW: begin
                mem_rd         = 1'b1;
                mem_in_sel     = 2'b00;
                input_row      = row_cnt_q;
                input_en       = mem_ready;
                input_count_en = mem_ready;
                if (input_j_cout && mem_ready) begin
                    if (row_cnt_q == C_LAST_ROW) state_d   = S_SETUP;
                    else                         row_cnt_d = row_cnt_q + 1'b1;
                end
            end
            S_SETUP: begin
                tab_count_ld = 1'b1;
                state_d      = S_WIN;
            end
            S_WIN: begin
                table_ld = 1'b1;
                mac_rst  = 1'b1;
                state_d  = S_CALC;
            end
            S_CALC: begin
                mac_ld        = 1'b1;
                calc_count_en = 1'b1;
                if (calc_done) state_d = S_BUF;
            end
            S_BUF: begin
                write_buf_ld = 1'b1;
                wr_count_en  = 1'b1;
                if (write_mem_cout || it_ends) state_d = S_WRITE;
                else if (table_cout)           state_d = S_SHIFT;
                else                           state_d = S_ADV;
            end
            S_ADV: begin
                win_count_en = 1'b1;
                state_d      = S_WIN;
            end
            S_WRITE: begin
                mem_wr      = 1'b1;
                mem_in_sel  = 2'b10;
                out_base_en = mem_ready;
                if (mem_ready) begin
                    if (it_ends)         state_d = S_NEXT_FILT;
                    else if (table_cout) state_d = S_SHIFT;
                    else                 state_d = S_ADV;
                end
            end
            // Older rows slide up in the buffer; only the bottom row is refetched.
            S_SHIFT: begin
                shift_en    = 1'b1;
                in_count_en = 1'b1;
                table_ld    = 1'b1;
                row_cnt_d   = C_LAST_ROW;
                state_d     = S_LD_ROW;
            end
            S_NEXT_FILT: begin
                if (filt_idx_q == C_LAST_FILT) begin
                    state_d = S_DONE;
                end else begin
                    filt_idx_d = filt_idx_q + 1'b1;
                    in_rewind  = 1'b1;
                    state_d    = S_LD_FILT;
                end
            end
            S_DONE: begin
                done    = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign filt_idx = filt_idx_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            row_cnt_q  <= '0;
            filt_idx_q <= '0;
        end else begin
            state_q    <= state_d;
            row_cnt_q  <= row_cnt_d;
            filt_idx_q <= filt_idx_d;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_conv_ctrl_param.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_conv_ctrl_param: job-level reference model driving random flags/stalls. |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module tb_conv_ctrl_param;

    localparam int FR = 3;
    localparam int NF = 2;
    localparam int RW = (FR > 1) ? $clog2(FR) : 1;
    localparam int FW = (NF > 1) ? $clog2(NF) : 1;

    logic clk            = 1'b0;
    logic rst_n          = 1'b0;
    logic start          = 1'b0;
    logic mem_ready      = 1'b0;
    logic filt_cout      = 1'b0;
    logic input_j_cout   = 1'b0;
    logic calc_done      = 1'b0;
    logic write_mem_cout = 1'b0;
    logic table_cout     = 1'b0;
    logic it_ends        = 1'b0;

    logic          busy, done, base_ld, in_rewind, out_base_en, mem_rd, mem_wr;
    logic [1:0]    mem_in_sel;
    logic          filt_ld, filt_count_en, input_en, input_count_en;
    logic [RW-1:0] input_row;
    logic          tab_count_ld, table_ld, mac_rst, mac_ld, calc_count_en;
    logic          write_buf_ld, wr_count_en, win_count_en, shift_en, in_count_en;
    logic [FW-1:0] filt_idx;

    conv_ctrl_param #(.FILT_ROWS(FR), .NUM_FILT(NF)) u_dut (
        .clk(clk), .rst_n(rst_n), .start(start), .mem_ready(mem_ready),
        .filt_cout(filt_cout), .input_j_cout(input_j_cout), .calc_done(calc_done),
        .write_mem_cout(write_mem_cout), .table_cout(table_cout), .it_ends(it_ends),
        .busy(busy), .done(done), .base_ld(base_ld), .in_rewind(in_rewind),
        .out_base_en(out_base_en), .mem_rd(mem_rd), .mem_wr(mem_wr),
        .mem_in_sel(mem_in_sel), .filt_ld(filt_ld), .filt_count_en(filt_count_en),
        .input_en(input_en), .input_count_en(input_count_en), .input_row(input_row),
        .tab_count_ld(tab_count_ld), .table_ld(table_ld), .mac_rst(mac_rst),
        .mac_ld(mac_ld), .calc_count_en(calc_count_en), .write_buf_ld(write_buf_ld),
        .wr_count_en(wr_count_en), .win_count_en(win_count_en), .shift_en(shift_en),
        .in_count_en(in_count_en), .filt_idx(filt_idx)
    );

    always #5 clk = ~clk;

    int total    = 0;
    int bad      = 0;
    int cur_filt = 0;

    logic          e_busy, e_done, e_base_ld, e_in_rewind, e_out_base_en, e_mem_rd, e_mem_wr;
    logic [1:0]    e_sel;
    logic          e_filt_ld, e_filt_cnt, e_in_en, e_in_cnt;
    logic [RW-1:0] e_row;
    logic          e_tab_cnt_ld, e_table_ld, e_mac_rst, e_mac_ld, e_calc_cnt;
    logic          e_wbuf_ld, e_wr_cnt, e_win_cnt, e_shift, e_inc_cnt;
    logic [FW-1:0] e_fidx;

    logic [63:0] w_obs, w_exp;

    assign w_obs = 64'({busy, done, base_ld, in_rewind, out_base_en, mem_rd, mem_wr,
                        mem_in_sel, filt_ld, filt_count_en, input_en, input_count_en,
                        input_row, tab_count_ld, table_ld, mac_rst, mac_ld, calc_count_en,
                        write_buf_ld, wr_count_en, win_count_en, shift_en, in_count_en,
                        filt_idx});
    assign w_exp = 64'({e_busy, e_done, e_base_ld, e_in_rewind, e_out_base_en, e_mem_rd, e_mem_wr,
                        e_sel, e_filt_ld, e_filt_cnt, e_in_en, e_in_cnt,
                        e_row, e_tab_cnt_ld, e_table_ld, e_mac_rst, e_mac_ld, e_calc_cnt,
                        e_wbuf_ld, e_wr_cnt, e_win_cnt, e_shift, e_inc_cnt,
                        e_fidx});

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s @%0t: got=%h expected=%h", tag, $time, got, exp);
        end
    endtask

    function automatic logic rb();
        return 1'($urandom_range(0, 1));
    endfunction

    // Every output idle except busy and the current filter index.
    task automatic clr(input logic b);
        {e_done, e_base_ld, e_in_rewind, e_out_base_en, e_mem_rd, e_mem_wr, e_sel,
         e_filt_ld, e_filt_cnt, e_in_en, e_in_cnt, e_row, e_tab_cnt_ld, e_table_ld,
         e_mac_rst, e_mac_ld, e_calc_cnt, e_wbuf_ld, e_wr_cnt, e_win_cnt, e_shift,
         e_inc_cnt} = '0;
        e_busy = b;
        e_fidx = FW'(cur_filt);
    endtask

    // Flags the current phase does not care about are left random.
    task automatic noise();
        start          = rb();
        mem_ready      = rb();
        filt_cout      = rb();
        input_j_cout   = rb();
        calc_done      = rb();
        write_mem_cout = rb();
        table_cout     = rb();
        it_ends        = rb();
    endtask

    task automatic tick(input string tag);
        #1;
        chk(tag, w_obs, w_exp);
        @(posedge clk);
        #1;
    endtask

    task automatic load_filt(input bit directed);
        int n;
        int acc;
        n   = directed ? 4 : $urandom_range(1, 4);
        acc = 0;
        while (acc < n) begin
            noise();
            mem_ready = directed ? 1'b1 : ($urandom_range(0, 3) != 0);
            if (mem_ready) filt_cout = (acc == n - 1);
            clr(1'b1);
            e_mem_rd = 1'b1; e_sel = 2'b01; e_filt_ld = mem_ready; e_filt_cnt = mem_ready;
            tick("ld_filt");
            if (mem_ready) acc++;
        end
    endtask

    task automatic load_row(input int r, input bit directed);
        int n;
        int acc;
        int stall;
        n     = directed ? 5 : $urandom_range(1, 3);
        acc   = 0;
        stall = (directed && r == 1) ? 3 : 0;
        while (acc < n) begin
            noise();
            if (directed) begin
                mem_ready = !(acc == 2 && stall > 0);
                if (!mem_ready) stall--;
            end else begin
                mem_ready = ($urandom_range(0, 3) != 0);
            end
            if (mem_ready) input_j_cout = (acc == n - 1);
            clr(1'b1);
            e_mem_rd = 1'b1; e_sel = 2'b00; e_row = RW'(r);
            e_in_en = mem_ready; e_in_cnt = mem_ready;
            tick("ld_row");
            if (mem_ready) acc++;
        end
    endtask

    task automatic setup();
        noise(); clr(1'b1); e_tab_cnt_ld = 1'b1; tick("setup");
    endtask

    // Returns 0 = next window, 1 = shift, 2 = filter finished.
    task automatic do_write(input bit ending, input bit directed, output int next);
        logic rdy;
        next = -1;
        while (next < 0) begin
            noise();
            mem_ready = directed ? 1'b1 : ($urandom_range(0, 3) != 0);
            rdy = mem_ready;
            if (rdy) begin
                it_ends = ending;
                if (directed) table_cout = 1'b0;
                next = it_ends ? 2 : (table_cout ? 1 : 0);
            end
            clr(1'b1);
            e_mem_wr = 1'b1; e_sel = 2'b10; e_out_base_en = rdy;
            tick("write");
        end
    endtask

    task automatic run_filter(input int f, input bit directed);
        int n_win;
        int wins;
        int n_calc;
        int next;
        bit b_wm, b_ie, b_tc, fin;
        load_filt(directed);
        for (int r = 0; r < FR; r++) load_row(r, directed);
        setup();
        n_win = directed ? 3 : $urandom_range(1, 5);
        wins  = 0;
        fin   = 1'b0;
        while (!fin) begin
            noise(); clr(1'b1); e_table_ld = 1'b1; e_mac_rst = 1'b1; tick("win");
            n_calc = directed ? 9 : $urandom_range(1, 4);
            for (int k = 0; k < n_calc; k++) begin
                noise();
                calc_done = (k == n_calc - 1);
                clr(1'b1); e_mac_ld = 1'b1; e_calc_cnt = 1'b1;
                tick("calc");
            end
            wins++;
            noise();
            if (directed) begin
                write_mem_cout = 1'b0;
                table_cout     = (wins == 2);
            end
            it_ends = (wins >= n_win);
            b_wm = write_mem_cout; b_ie = it_ends; b_tc = table_cout;
            clr(1'b1); e_wbuf_ld = 1'b1; e_wr_cnt = 1'b1;
            tick("buf");
            if (b_wm || b_ie) do_write(wins >= n_win, directed, next);
            else              next = b_tc ? 1 : 0;
            if (next == 0) begin
                noise(); clr(1'b1); e_win_cnt = 1'b1; tick("adv");
            end else if (next == 1) begin
                noise(); clr(1'b1); e_shift = 1'b1; e_inc_cnt = 1'b1; e_table_ld = 1'b1;
                tick("shift");
                load_row(FR - 1, directed);
                setup();
            end else begin
                fin = 1'b1;
            end
        end
        noise(); clr(1'b1); e_in_rewind = (f < NF - 1); tick("next_filt");
        if (f < NF - 1) cur_filt = f + 1;
    endtask

    task automatic run_job(input bit directed);
        noise(); start = 1'b1; clr(1'b0); tick("idle_start");
        noise(); clr(1'b1); e_base_ld = 1'b1; tick("init");
        cur_filt = 0;
        for (int f = 0; f < NF; f++) run_filter(f, directed);
        noise(); clr(1'b1); e_done = 1'b1; tick("done");
        noise(); start = 1'b0; clr(1'b0); tick("idle_after");
    endtask

    initial begin
        noise();
        repeat (2) @(posedge clk);
        #1;
        repeat (3) begin
            noise(); clr(1'b0); tick("reset");
        end
        rst_n = 1'b1;
        repeat (10) begin
            noise(); start = 1'b0; clr(1'b0); tick("idle");
        end

        run_job(1'b1);
        repeat (6) run_job(1'b0);

        // Abort mid-job: outputs drop at once and no done pulse follows.
        noise(); start = 1'b1; clr(1'b0); tick("ab_idle");
        noise(); clr(1'b1); e_base_ld = 1'b1; tick("ab_init");
        cur_filt = 0;
        repeat (2) begin
            noise(); mem_ready = 1'b0; clr(1'b1); e_mem_rd = 1'b1; e_sel = 2'b01;
            tick("ab_ld_filt");
        end
        rst_n = 1'b0;
        repeat (3) begin
            noise(); clr(1'b0); tick("ab_rst");
        end
        rst_n = 1'b1;
        repeat (5) begin
            noise(); start = 1'b0; clr(1'b0); tick("ab_idle_after");
        end

        run_job(1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
